// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command wrapper.
package uart_pkg;

  // 50 MHz system clock / 19200 baud.
  localparam int unsigned DefaultBaudDiv = 2604;

  // A command frame is cmd, data[15:8], data[7:0].
  localparam int unsigned FrameBytes = 3;

  // Frame assembly position; one state per expected byte.
  typedef enum logic [$clog2(FrameBytes)-1:0] {
    StWaitCmd,
    StWaitHi,
    StWaitLo
  } frame_state_e;

  typedef enum logic {
    StRxIdle,
    StRxRun
  } rx_state_e;

  typedef enum logic {
    StTxIdle,
    StTxRun
  } tx_state_e;

endpackage

// File: rtl/uart.sv
// Byte-level 8N1 UART: independent receive and transmit halves.
module uart
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DefaultBaudDiv
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx_busy
);

  localparam int unsigned CntW = $clog2(2 * BAUD_DIV);
  // Half a bit to reach mid-start, plus one bit to reach mid-data0, folded into one wait.
  localparam logic [CntW-1:0] FirstWait = CntW'(BAUD_DIV + BAUD_DIV / 2 - 1);
  localparam logic [CntW-1:0] BitWait   = CntW'(BAUD_DIV - 1);

  // ---------------- receive half ----------------
  logic [1:0]      rx_sync_q;
  logic            rx_last_q;
  logic            rx_s;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]      rx_bits_q, rx_bits_d;
  logic [7:0]      rx_shift_q, rx_shift_d;

  assign rx_s = rx_sync_q[1];

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q <= 2'b11;
      rx_last_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], RX};
      rx_last_q <= rx_sync_q[1];
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= StRxIdle;
      rx_cnt_q   <= '0;
      rx_bits_q  <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bits_q  <= rx_bits_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // Receiver next state: 8 data samples then one stop sample, which releases the byte.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bits_d  = rx_bits_q;
    rx_shift_d = rx_shift_q;
    rx_rdy     = 1'b0;
    case (rx_state_q)
      StRxIdle: begin
        if (rx_last_q && !rx_s) begin
          rx_state_d = StRxRun;
          rx_cnt_d   = FirstWait;
          rx_bits_d  = '0;
        end
      end
      StRxRun: begin
        if (rx_cnt_q == '0) begin
          if (rx_bits_q == 4'd8) begin
            // Stop sample: level is not checked.
            rx_rdy     = 1'b1;
            rx_state_d = StRxIdle;
          end else begin
            rx_shift_d = {rx_s, rx_shift_q[7:1]};
            rx_bits_d  = rx_bits_q + 4'd1;
            rx_cnt_d   = BitWait;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CntW'(1);
        end
      end
      default: rx_state_d = StRxIdle;
    endcase
  end

  assign rx_data = rx_shift_q;

  // ---------------- transmit half ----------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bits_q, tx_bits_d;
  logic [9:0]      tx_shift_q, tx_shift_d;

  // Transmitter state register; the shifter idles all-ones so TX rests high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= StTxIdle;
      tx_cnt_q   <= '0;
      tx_bits_q  <= '0;
      tx_shift_q <= '1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bits_q  <= tx_bits_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // Transmitter next state: load start/data/stop, shift once per bit period.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bits_d  = tx_bits_q;
    tx_shift_d = tx_shift_q;
    tx_done    = 1'b0;
    case (tx_state_q)
      StTxIdle: begin
        if (trmt) begin
          tx_state_d = StTxRun;
          tx_shift_d = {1'b1, tx_data, 1'b0};
          tx_cnt_d   = '0;
          tx_bits_d  = '0;
        end
      end
      StTxRun: begin
        if (tx_cnt_q == BitWait) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          if (tx_bits_q == 4'd9) begin
            tx_done    = 1'b1;
            tx_state_d = StTxIdle;
          end else begin
            tx_bits_d = tx_bits_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      default: tx_state_d = StTxIdle;
    endcase
  end

  assign TX      = tx_shift_q[0];
  assign tx_busy = (tx_state_q == StTxRun);

endmodule

// File: rtl/uart_wrapper.sv
// Assembles 3-byte command frames from the UART and handles the response handshake.
module uart_wrapper
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DefaultBaudDiv
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       tx_done;
  logic       tx_busy;
  logic       accept;

  uart #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .TX     (TX),
    .rx_rdy (rx_rdy),
    .rx_data(rx_data),
    .trmt   (send_resp),
    .tx_data(resp),
    .tx_done(tx_done),
    .tx_busy(tx_busy)
  );

  // The uart ignores trmt while busy; mirror that to know when a request was taken.
  assign accept = send_resp && !tx_busy;

  frame_state_e state_q, state_d;
  logic [7:0]   cmd_q, cmd_d;
  logic [15:0]  data_q, data_d;
  logic         cmd_rdy_q, cmd_rdy_d;
  logic         resp_sent_q, resp_sent_d;

  // Frame FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWaitCmd;
      cmd_q       <= '0;
      data_q      <= '0;
      cmd_rdy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      cmd_rdy_q   <= cmd_rdy_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  // Next state: the frame-complete set is applied after the clear so it wins.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    cmd_rdy_d   = cmd_rdy_q;
    resp_sent_d = resp_sent_q;

    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;

    if (rx_rdy) begin
      case (state_q)
        StWaitCmd: begin
          cmd_d     = rx_data;
          cmd_rdy_d = 1'b0;
          state_d   = StWaitHi;
        end
        StWaitHi: begin
          data_d[15:8] = rx_data;
          state_d      = StWaitLo;
        end
        StWaitLo: begin
          data_d[7:0] = rx_data;
          cmd_rdy_d   = 1'b1;
          state_d     = StWaitCmd;
        end
        default: state_d = StWaitCmd;
      endcase
    end

    if (accept) begin
      resp_sent_d = 1'b0;
    end else if (tx_done) begin
      resp_sent_d = 1'b1;
    end
  end

  assign cmd       = cmd_q;
  assign data      = data_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_wrapper.sv
// Scoreboard bench for uart_wrapper: host-side serial model drives RX and decodes TX.
module tb_uart_wrapper;

  localparam int unsigned BaudDiv = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  uart_wrapper #(
    .BAUD_DIV(BaudDiv)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .data       (data),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .send_resp  (send_resp),
    .resp_sent  (resp_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  c;
    logic [15:0] d;
  } frame_t;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned last_start = 0;
  frame_t      exp_frames[$];
  logic [7:0]  exp_resp[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int unsigned act, input int unsigned lo,
                             input int unsigned hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Host transmits one 8N1 byte on RX.
  task automatic host_send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      if (i == 0) last_start = cyc;
      repeat (BaudDiv) @(negedge clk);
    end
  endtask

  task automatic host_send_frame(input logic [7:0] c, input logic [15:0] d);
    exp_frames.push_back({c, d});
    host_send_byte(c);
    host_send_byte(d[15:8]);
    host_send_byte(d[7:0]);
  endtask

  // Request a response byte and check resp_sent arrives after ten bit periods.
  task automatic do_response(input logic [7:0] b);
    int n;
    @(negedge clk);
    resp      = b;
    send_resp = 1'b1;
    exp_resp.push_back(b);
    @(negedge clk);
    send_resp = 1'b0;
    check("resp_sent_clear", {31'd0, resp_sent}, 32'd0);
    n = 0;
    while (resp_sent !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("resp_sent_latency", n, 32'd160);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  // Frame monitor: every rising cmd_rdy must match the oldest pending frame.
  logic   fm_prev = 1'b0;
  frame_t fm_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (cmd_rdy === 1'b1 && !fm_prev) begin
        if (exp_frames.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd_rdy: cmd=0x%0h data=0x%0h, no frame pending", cmd, data);
        end else begin
          fm_exp = exp_frames.pop_front();
          check("frame_cmd", {24'd0, cmd}, {24'd0, fm_exp.c});
          check("frame_data", {16'd0, data}, {16'd0, fm_exp.d});
          check_range("frame_latency", cyc - last_start, 145, 160);
        end
      end
      fm_prev = (cmd_rdy === 1'b1);
    end
  end

  // TX monitor: host-side receiver sampling each bit at its middle.
  logic       tm_prev = 1'b1;
  logic [7:0] tm_byte;
  logic       tm_stop;
  initial begin
    forever begin
      @(negedge clk);
      if (tm_prev && TX === 1'b0) begin
        repeat (BaudDiv / 2) @(negedge clk);
        check("tx_start_bit", {31'd0, TX}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BaudDiv) @(negedge clk);
          tm_byte[i] = TX;
        end
        repeat (BaudDiv) @(negedge clk);
        tm_stop = TX;
        check("tx_stop_bit", {31'd0, tm_stop}, 32'd1);
        if (exp_resp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_tx_byte: got 0x%0h, none pending", tm_byte);
        end else begin
          check("tx_byte", {24'd0, tm_byte}, {24'd0, exp_resp.pop_front()});
        end
      end
      tm_prev = (TX === 1'b1);
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  int          clr_wait;
  int          drain;
  logic [7:0]  r_c;
  logic [15:0] r_d;
  logic [7:0]  r_r;
  int unsigned r_gap;

  initial begin
    rst_n       = 1'b0;
    RX          = 1'b1;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    resp        = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_cmd", {24'd0, cmd}, 32'd0);
    check("rst_data", {16'd0, data}, 32'd0);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("rst_resp_sent", {31'd0, resp_sent}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic frame, held until cleared.
    host_send_frame(8'h02, 16'h1234);
    repeat (100) @(negedge clk);
    check("hold_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("hold_cmd", {24'd0, cmd}, 32'h02);
    check("hold_data", {16'd0, data}, 32'h1234);
    pulse_clr();
    check("clr_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("clr_keeps_cmd", {24'd0, cmd}, 32'h02);

    // Response byte.
    do_response(8'hA5);
    repeat (20) @(negedge clk);
    check("resp_sent_holds", {31'd0, resp_sent}, 32'd1);
    check("tx_idle_high", {31'd0, TX}, 32'd1);

    // Back-to-back frames with no clear.
    host_send_frame(8'h05, 16'h01FF);
    repeat (10) @(negedge clk);
    check("b2b_rdy_held", {31'd0, cmd_rdy}, 32'd1);
    exp_frames.push_back({8'h08, 16'h0000});
    host_send_byte(8'h08);
    check("b2b_rdy_drop", {31'd0, cmd_rdy}, 32'd0);
    check("b2b_new_cmd", {24'd0, cmd}, 32'h08);
    host_send_byte(8'h00);
    host_send_byte(8'h00);
    repeat (10) @(negedge clk);

    // Reset in the middle of a frame discards it.
    host_send_byte(8'h03);
    host_send_byte(8'hAB);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_cmd", {24'd0, cmd}, 32'd0);
    check("mid_rst_data", {16'd0, data}, 32'd0);
    check("mid_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("mid_rst_resp_sent", {31'd0, resp_sent}, 32'd0);
    check("mid_rst_tx", {31'd0, TX}, 32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    host_send_frame(8'h04, 16'h0010);
    repeat (10) @(negedge clk);
    check("post_rst_rdy", {31'd0, cmd_rdy}, 32'd1);
    pulse_clr();

    // Clear held across the set edge: set must win.
    exp_frames.push_back({8'h07, 16'hBEEF});
    host_send_byte(8'h07);
    host_send_byte(8'hBE);
    fork
      host_send_byte(8'hEF);
      begin
        clr_cmd_rdy = 1'b1;
        clr_wait    = 0;
        while (cmd_rdy !== 1'b1 && clr_wait < 400) begin
          @(negedge clk);
          clr_wait++;
        end
        clr_cmd_rdy = 1'b0;
      end
    join
    check("set_wins_no_timeout", {31'd0, clr_wait < 400}, 32'd1);
    check("set_wins_rdy", {31'd0, cmd_rdy}, 32'd1);
    pulse_clr();

    // Second send_resp while busy is ignored.
    fork
      do_response(8'h3C);
      begin
        repeat (70) @(negedge clk);
        resp      = 8'hFF;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
      end
    join
    repeat (300) @(negedge clk);
    check("busy_ignore_sent", {31'd0, resp_sent}, 32'd1);
    check("busy_ignore_tx", {31'd0, TX}, 32'd1);

    // Full duplex.
    fork
      host_send_frame(8'h06, 16'h0000);
      do_response(8'h0A);
    join
    repeat (20) @(negedge clk);
    pulse_clr();

    // Randomised full-duplex traffic.
    for (int k = 0; k < 5; k++) begin
      r_c   = 8'($urandom);
      r_d   = 16'($urandom);
      r_r   = 8'($urandom);
      r_gap = $urandom_range(0, 200);
      fork
        host_send_frame(r_c, r_d);
        begin
          repeat (r_gap) @(negedge clk);
          do_response(r_r);
        end
      join
      repeat (20) @(negedge clk);
      pulse_clr();
      check("rand_clr", {31'd0, cmd_rdy}, 32'd0);
    end

    drain = 0;
    while ((exp_frames.size() != 0 || exp_resp.size() != 0) && drain < 2000) begin
      @(negedge clk);
      drain++;
    end
    check("frames_drained", exp_frames.size(), 32'd0);
    check("resp_drained", exp_resp.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_wrapper.md
UART_WRAPPER -- requirements
Module: uart_wrapper

Interface
REQ-001 Parameter BAUD_DIV, default 2604, gives clk cycles per UART bit (50 MHz clk, 19200 baud).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 RX  input  1  serial line from the host.
REQ-005 TX  output  1  serial line to the host.
REQ-006 cmd  output  8  received command byte.
REQ-007 data  output  16  received data word.
REQ-008 cmd_rdy  output  1  level, high when cmd/data hold a complete frame.
REQ-009 clr_cmd_rdy  input  1  pulse that knocks down cmd_rdy.
REQ-010 resp  input  8  response byte to send to the host.
REQ-011 send_resp  input  1  pulse that starts transmission of resp.
REQ-012 resp_sent  output  1  level, high once a response byte has fully left on TX.

Function
REQ-013 Line format SHALL be 8N1: start 0, 8 data bits LSB first, stop 1, BAUD_DIV cycles per bit.
REQ-014 RX SHALL pass through two flops preset to 1 before any use (metastability guard).
REQ-015 Receiver SHALL detect a start on a falling edge, wait BAUD_DIV/2 cycles, then sample every BAUD_DIV cycles.
- 8 data samples, then 1 stop sample.
- After the stop sample it SHALL raise internal rx_rdy for 1 cycle with the byte; a bad stop bit is not checked.
REQ-016 Frame SHALL be 3 bytes in order: cmd, data[15:8], data[7:0].
- Assembly FSM states: WAIT_CMD -> WAIT_HI -> WAIT_LO -> WAIT_CMD.
- Each transition occurs on rx_rdy.
REQ-017 On rx_rdy in WAIT_CMD: cmd SHALL load the byte and cmd_rdy SHALL clear.
REQ-018 On rx_rdy in WAIT_HI: data[15:8] SHALL load the byte.
REQ-019 On rx_rdy in WAIT_LO: data[7:0] SHALL load the byte and cmd_rdy SHALL set on the next edge, 1 cycle after the stop sample.
REQ-020 cmd and data SHALL stay stable while cmd_rdy=1 until the next frame's first byte completes.
REQ-021 clr_cmd_rdy SHALL clear cmd_rdy; if it coincides with the set, set SHALL win.
REQ-022 Transmitter SHALL latch resp on send_resp when idle and drive start/data/stop with TX idle high.
- send_resp while busy SHALL be ignored.
REQ-023 resp_sent SHALL clear on an accepted send_resp and set on the cycle the stop bit period ends.
REQ-024 Receive and transmit SHALL run fully independently (full duplex).

Reset
REQ-025 On rst_n low, asynchronously and regardless of any in-progress byte:
- FSM to WAIT_CMD; receiver and transmitter idle.
- TX=1, cmd=0x00, data=0x0000, cmd_rdy=0, resp_sent=0.
- Sync flops=1; bit and baud counters=0.
REQ-026 A partial frame in progress at reset SHALL be discarded; no cmd_rdy SHALL result from it.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state enum, the default BAUD_DIV and the frame byte count (3).
REQ-028 Byte-level serial logic SHALL be one sub-module, uart, with an rx half and a tx half.
- uart exposes rx_rdy/rx_data and trmt/tx_data/tx_done.
- uart_wrapper holds only the frame FSM, output registers and the handshake flags.

Verification (benches use BAUD_DIV=16; host model is the existing remote command master)
REQ-029 Send frame 0x02,0x12,0x34 -> cmd_rdy rises 1 cycle after the last stop sample with cmd=0x02, data=0x1234; it holds until clr_cmd_rdy.
REQ-030 send_resp with resp=0xA5 -> TX shows 0, then 1,0,1,0,0,1,0,1, then 1, at 16 cycles each; resp_sent rises after 160 cycles.
REQ-031 Back-to-back frames 0x05,0x01,0xFF then 0x08,0x00,0x00 with no clr -> cmd_rdy drops at the end of byte 4 and re-rises with cmd=0x08, data=0x0000.
REQ-032 rst_n pulsed low after 2 bytes of frame 0x03,0xAB,0xCD, then frame 0x04,0x00,0x10 sent -> no cmd_rdy for the partial frame; cmd=0x04, data=0x0010.
REQ-033 clr_cmd_rdy asserted on the same cycle cmd_rdy sets -> cmd_rdy=1.
- send_resp re-pulsed mid-transmit -> the first byte is unaffected and no second byte is sent.
REQ-034 Simultaneous receive of 0x06,0x00,0x00 and transmit of 0x0A -> both complete correctly; cmd=0x06 and host resp=0x0A.
